imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 121 ++++++++++++
 tb/tb_imem_loader.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Byte-stream instruction memory loader: assembles little-endian words from a
// valid/ready byte stream and writes them sequentially from BASE_ADDR.
module imem_loader #(
  parameter int unsigned D_WIDTH     = 8,
  parameter int unsigned EXT_WIDTH   = 32,
  parameter int unsigned DEPTH_BYTES = 4096,
  parameter logic [EXT_WIDTH-1:0] BASE_ADDR = 32'hBFC00000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [10:0]          len_words,
  input  logic [D_WIDTH-1:0]   in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 we,
  output logic [EXT_WIDTH-1:0] wa,
  output logic [EXT_WIDTH-1:0] wd,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic                 cpu_hold
);

  localparam int unsigned BPW = EXT_WIDTH / D_WIDTH;
  localparam int unsigned BCW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [11:0] MAX_WORDS = 12'(DEPTH_BYTES / (EXT_WIDTH / 8));

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RECV  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]           state_reg;
  logic [10:0]          len_reg;
  logic [10:0]          word_idx_reg;
  logic [BCW-1:0]       byte_cnt_reg;
  logic [EXT_WIDTH-1:0] word_reg;
  logic [EXT_WIDTH-1:0] wa_reg;
  logic [EXT_WIDTH-1:0] wd_reg;
  logic                 err_reg;

  logic                 xfer;
  logic                 last_byte;
  logic [EXT_WIDTH-1:0] word_next;
  logic [EXT_WIDTH-1:0] wa_next;
  logic [10:0]          word_idx_inc;

  assign xfer         = in_valid && in_ready;
  assign last_byte    = (byte_cnt_reg == BCW'(BPW - 1));
  assign wa_next      = BASE_ADDR + EXT_WIDTH'(word_idx_reg) * EXT_WIDTH'(EXT_WIDTH / 8);
  assign word_idx_inc = word_idx_reg + 11'd1;

  // The incoming byte lands in the lane selected by the byte count; other lanes keep their value.
  genvar gi;
  generate
    for (gi = 0; gi < BPW; gi++) begin : g_lane
      assign word_next[gi*D_WIDTH +: D_WIDTH] =
        (byte_cnt_reg == BCW'(gi)) ? in_data : word_reg[gi*D_WIDTH +: D_WIDTH];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      len_reg      <= '0;
      word_idx_reg <= '0;
      byte_cnt_reg <= '0;
      word_reg     <= '0;
      wa_reg       <= '0;
      wd_reg       <= '0;
      err_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            len_reg      <= len_words;
            err_reg      <= 1'b0;
            word_idx_reg <= '0;
            byte_cnt_reg <= '0;
            if (len_words == 11'd0) begin
              state_reg <= DONE;
            end else if ({1'b0, len_words} > MAX_WORDS) begin
              err_reg   <= 1'b1;
              state_reg <= DONE;
            end else begin
              state_reg <= RECV;
            end
          end
        end
        RECV: begin
          if (xfer) begin
            word_reg     <= word_next;
            byte_cnt_reg <= last_byte ? '0 : byte_cnt_reg + BCW'(1);
            if (last_byte) begin
              // Capture address and data here so they are stable for the whole WRITE cycle.
              wd_reg    <= word_next;
              wa_reg    <= wa_next;
              state_reg <= WRITE;
            end
          end
        end
        WRITE: begin
          word_idx_reg <= word_idx_inc;
          state_reg    <= (word_idx_inc == len_reg) ? DONE : RECV;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready = (state_reg == RECV);
  assign we       = (state_reg == WRITE);
  assign wa       = wa_reg;
  assign wd       = wd_reg;
  assign busy     = (state_reg == RECV) || (state_reg == WRITE);
  assign done     = (state_reg == DONE);
  assign err      = err_reg;
  assign cpu_hold = !((state_reg == DONE) && !err_reg);

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: stimulus queues expected writes, a monitor
// pops and checks them whenever we is seen; status outputs are checked directly.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [10:0] len_words;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        we;
  logic [31:0] wa;
  logic [31:0] wd;
  logic        busy;
  logic        done;
  logic        err;
  logic        cpu_hold;

  int vec_cnt    = 0;
  int miscmp_cnt = 0;
  int cycle      = 0;

  logic [63:0] exp_q[$];

  imem_loader dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .len_words(len_words),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .we       (we),
    .wa       (wa),
    .wd       (wd),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .cpu_hold (cpu_hold)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // Monitor: every write the DUT presents must match the head of the scoreboard.
  always @(negedge clk) begin
    if (we) begin
      vec_cnt++;
      if (exp_q.size() == 0) begin
        miscmp_cnt++;
        $display("FAIL unexpected_write: got wa=%h wd=%h, required no write", wa, wd);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if ({wa, wd} !== e) begin
          miscmp_cnt++;
          $display("FAIL write: got wa=%h wd=%h, required wa=%h wd=%h", wa, wd, e[63:32], e[31:0]);
        end else begin
          $display("write wa=%h wd=%h ok", wa, wd);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miscmp_cnt++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end else begin
      $display("check %s = %h ok", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [10:0] len);
    start = 1'b1;
    len_words = len;
    tick();
    start = 1'b0;
  endtask

  // Presents one byte and holds it until the handshake edge; in_valid is left high.
  task automatic send_byte(input logic [7:0] b);
    int waited;
    in_valid = 1'b1;
    in_data  = b;
    waited   = 0;
    while (!in_ready && waited < 20) begin
      tick();
      waited++;
    end
    if (!in_ready) begin
      vec_cnt++;
      miscmp_cnt++;
      $display("FAIL in_ready_timeout: got 0 after %0d cycles, required 1", waited);
    end
    tick();
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8]);
  endtask

  task automatic expect_write(input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  initial begin
    int c0;
    int c9;
    logic done9;
    rst = 1'b1; start = 1'b0; len_words = '0; in_data = '0; in_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset values
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_we",       {31'b0, we},       32'd0);
    chk("rst_wa",       wa,                32'd0);
    chk("rst_wd",       wd,                32'd0);
    chk("rst_busy",     {31'b0, busy},     32'd0);
    chk("rst_done",     {31'b0, done},     32'd0);
    chk("rst_err",      {31'b0, err},      32'd0);
    chk("rst_cpu_hold", {31'b0, cpu_hold}, 32'd1);

    // Byte presented in IDLE must not be consumed
    in_valid = 1'b1; in_data = 8'hFF;
    tick();
    chk("idle_in_ready", {31'b0, in_ready}, 32'd0);
    in_valid = 1'b0;

    // Two words back-to-back; done ten cycles after the first byte is presented
    expect_write(32'hBFC00000, 32'h00500013);
    expect_write(32'hBFC00004, 32'h00100093);
    do_start(11'd2);
    chk("recv_busy", {31'b0, busy}, 32'd1);
    c0 = cycle;
    send_word(32'h00500013);
    send_word(32'h00100093);
    in_valid = 1'b0;
    c9 = cycle - c0;
    done9 = done;
    tick();
    chk("b2b_cycles", 32'(c9), 32'd9);
    chk("b2b_done_early", {31'b0, done9}, 32'd0);
    chk("b2b_done", {31'b0, done}, 32'd1);
    chk("b2b_cpu_hold", {31'b0, cpu_hold}, 32'd0);
    chk("b2b_busy", {31'b0, busy}, 32'd0);

    // Gapped in_valid
    expect_write(32'hBFC00000, 32'hDEADBEEF);
    do_start(11'd1);
    chk("start_clears_done", {31'b0, done}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      logic [31:0] w;
      w = 32'hDEADBEEF;
      send_byte(w[8*k +: 8]);
      in_valid = 1'b0; in_data = 8'h77;
      tick();
    end
    tick();
    chk("gap_done", {31'b0, done}, 32'd1);

    // len_words = 0
    do_start(11'd0);
    chk("len0_done", {31'b0, done}, 32'd1);
    chk("len0_err",  {31'b0, err},  32'd0);
    chk("len0_cpu_hold", {31'b0, cpu_hold}, 32'd0);

    // len_words = 1025 rejected
    do_start(11'd1025);
    chk("len1025_err",  {31'b0, err},  32'd1);
    chk("len1025_done", {31'b0, done}, 32'd1);
    chk("len1025_cpu_hold", {31'b0, cpu_hold}, 32'd1);
    chk("len1025_in_ready", {31'b0, in_ready}, 32'd0);
    tick(); tick();

    // start during RECV ignored
    expect_write(32'hBFC00000, 32'h11223344);
    expect_write(32'hBFC00004, 32'h55667788);
    do_start(11'd2);
    chk("restart_clears_err", {31'b0, err}, 32'd0);
    send_byte(8'h44); send_byte(8'h33);
    in_valid = 1'b0;
    do_start(11'd5);
    send_byte(8'h22); send_byte(8'h11);
    send_word(32'h55667788);
    in_valid = 1'b0;
    tick();
    chk("restart_ignored_done", {31'b0, done}, 32'd1);

    // Reset mid-word discards partial bytes
    do_start(11'd1);
    send_byte(8'hAA); send_byte(8'hBB);
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", {31'b0, busy}, 32'd0);
    chk("midrst_cpu_hold", {31'b0, cpu_hold}, 32'd1);
    chk("midrst_done", {31'b0, done}, 32'd0);
    expect_write(32'hBFC00000, 32'hCAFEF00D);
    do_start(11'd1);
    send_word(32'hCAFEF00D);
    in_valid = 1'b0;
    tick();
    chk("midrst_reload_done", {31'b0, done}, 32'd1);

    // Full memory load
    for (int i = 0; i < 1024; i++) begin
      logic [31:0] w;
      w = {i[7:0], 8'h5A, 6'b0, i[9:8], ~i[7:0]};
      expect_write(32'hBFC00000 + 32'(i) * 32'd4, w);
    end
    do_start(11'd1024);
    for (int i = 0; i < 1024; i++) begin
      logic [31:0] w;
      w = {i[7:0], 8'h5A, 6'b0, i[9:8], ~i[7:0]};
      send_word(w);
    end
    in_valid = 1'b1; in_data = 8'h99;
    for (int k = 0; k < 10; k++) tick();
    in_valid = 1'b0;
    chk("full_done", {31'b0, done}, 32'd1);
    chk("full_err", {31'b0, err}, 32'd0);
    chk("full_cpu_hold", {31'b0, cpu_hold}, 32'd0);
    chk("full_last_wa", wa, 32'hBFC00FFC);

    tick(); tick();
    chk("pending_writes", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
    $finish;
  end

endmodule
